// File: rtl/float_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : float_accumulate (plus its float_add datapath)
// Purpose  : Streaming binary32 accumulator. Reduces each in_last-delimited
//            vector of products to one IEEE-754 sum. ADD_LATENCY partial
//            sums circulate in the pipelined adder. At end of vector they
//            are pair-reduced into a single result.
// Ports    : clk, reset (sync, active-high)
//            in_data[31:0], in_valid, in_last, in_ready  - element stream
//            out_data[31:0], out_valid                   - vector sum
//            out_count[31:0]  - elements summed (FLOAT_ACC_COUNT_EN only)
// Options  : `define FLOAT_ACC_COUNT_EN enables the element counter/out_count
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// float_add: binary32 adder, round-to-nearest-even, LATENCY register stages.
// ----------------------------------------------------------------------------
module float_add #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        in_valid,
  output logic [31:0] q,
  output logic        q_valid
);

  function automatic logic [31:0] f_add(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0] a, b;
    logic        a_nan, b_nan, a_inf, b_inf, sa, sb, s, rnd, is_zero;
    logic [7:0]  ea, eb, d;
    logic [4:0]  sh;
    logic [26:0] ma, mb, mb_sh, lost_mask, m;
    logic [27:0] sum;
    logic [9:0]  e;
    logic [24:0] rm;
    a_nan = (&a_in[30:23]) & (|a_in[22:0]);
    b_nan = (&b_in[30:23]) & (|b_in[22:0]);
    a_inf = (&a_in[30:23]) & ~(|a_in[22:0]);
    b_inf = (&b_in[30:23]) & ~(|b_in[22:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a_in[31] != b_in[31])))
      return 32'h7FC00000;
    if (a_inf) return a_in;
    if (b_inf) return b_in;
    // Order by magnitude so the subtraction below never goes negative.
    if (a_in[30:0] >= b_in[30:0]) begin
      a = a_in; b = b_in;
    end else begin
      a = b_in; b = a_in;
    end
    sa = a[31];
    sb = b[31];
    // Denormals share the exponent of the smallest normal, without hidden bit.
    ea = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma = {(a[30:23] != 8'd0), a[22:0], 3'b000};
    mb = {(b[30:23] != 8'd0), b[22:0], 3'b000};
    d  = ea - eb;
    sh = (d > 8'd27) ? 5'd27 : d[4:0];
    // Alignment keeps guard/round bits and folds everything below into sticky.
    lost_mask = (27'd1 << sh) - 27'd1;
    mb_sh = (mb >> sh) | {26'd0, |(mb & lost_mask)};
    e = {2'b00, ea};
    s = sa;
    if (sa == sb) begin
      sum = {1'b0, ma} + {1'b0, mb_sh};
      if (sum[27]) begin
        m = sum[27:1] | {26'd0, sum[0]};
        e = e + 10'd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = ma - mb_sh;
      // Normalise left, stopping at the denormal exponent floor.
      for (int i = 0; i < 27; i++) begin
        if (!m[26] && (e > 10'd1)) begin
          m = m << 1;
          e = e - 10'd1;
        end
      end
    end
    is_zero = (m == 27'd0);
    if (is_zero) s = sa & sb;
    rnd = m[2] & (m[1] | m[0] | m[3]);
    rm  = {1'b0, m[26:3]} + {24'd0, rnd};
    if (rm[24]) begin
      rm = rm >> 1;
      e  = e + 10'd1;
    end
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    return {s, (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
  endfunction

  logic [31:0]        r_q [LATENCY];
  logic [LATENCY-1:0] r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) r_q[i] <= '0;
      r_v <= '0;
    end else begin
      r_q[0] <= f_add(in1, in2);
      r_v[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_q[i] <= r_q[i-1];
        r_v[i] <= r_v[i-1];
      end
    end
  end

  assign q       = r_q[LATENCY-1];
  assign q_valid = r_v[LATENCY-1];

endmodule

// ----------------------------------------------------------------------------
// float_accumulate: top level.
// ----------------------------------------------------------------------------
module float_accumulate #(
  parameter int ADD_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid
`ifdef FLOAT_ACC_COUNT_EN
  ,output logic [31:0] out_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [3:0] c_LANES_MAX = 4'(ADD_LATENCY);

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [31:0]            r_out_data;
  logic [31:0]            r_pend;
  logic                   r_pend_full;
  logic [3:0]             r_lanes;
  logic [ADD_LATENCY-1:0] r_vsr;

  logic [31:0] w_add_q;
  logic        w_add_qv_unused;
  logic        w_issue;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic        w_emerge;
  logic        w_accept;
  logic        w_final;

  // Only results we issued ourselves (tracked since the last reset) count.
  assign w_emerge = r_vsr[ADD_LATENCY-1];
  assign w_accept = in_valid & r_in_ready;
  // With one live slot left, the next emerging result is the whole sum.
  assign w_final  = (r_state == S_DRAIN) && w_emerge && (r_lanes == 4'd1);

  float_add #(.LATENCY(ADD_LATENCY)) u_add (
    .clk      (clk),
    .reset    (reset),
    .in1      (w_in1),
    .in2      (w_in2),
    .in_valid (w_issue),
    .q        (w_add_q),
    .q_valid  (w_add_qv_unused)
  );

  always_comb begin
    w_issue = 1'b0;
    w_in1   = '0;
    w_in2   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_issue = 1'b1;
          w_in1   = in_data;
        end
      end
      S_ACCUM: begin
        // Issue every cycle so bubbles recirculate partial sums unchanged.
        w_issue = 1'b1;
        w_in1   = in_valid ? in_data : '0;
        w_in2   = w_emerge ? w_add_q : '0;
      end
      S_DRAIN: begin
        if (w_emerge && r_pend_full && (r_lanes != 4'd1)) begin
          w_issue = 1'b1;
          w_in1   = r_pend;
          w_in2   = w_add_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_lanes     <= '0;
      r_vsr       <= '0;
    end else begin
      r_vsr[0] <= w_issue;
      for (int i = 1; i < ADD_LATENCY; i++) r_vsr[i] <= r_vsr[i-1];
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lanes <= 4'd1;
            if (in_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (r_lanes != c_LANES_MAX) r_lanes <= r_lanes + 4'd1;
          if (w_accept && in_last) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_final) begin
            r_out_data  <= w_add_q;
            r_out_valid <= 1'b1;
            r_pend_full <= 1'b0;
            r_state     <= S_OUT;
          end else if (w_emerge) begin
            if (!r_pend_full) begin
              r_pend      <= w_add_q;
              r_pend_full <= 1'b1;
            end else begin
              r_pend_full <= 1'b0;
              r_lanes     <= r_lanes - 4'd1;
            end
          end
        end
        S_OUT: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_lanes    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

`ifdef FLOAT_ACC_COUNT_EN
  logic [31:0] r_cnt;
  logic [31:0] r_out_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_out_count <= '0;
    end else begin
      if (w_accept) r_cnt <= (r_state == S_IDLE) ? 32'd1 : r_cnt + 32'd1;
      if (w_final)  r_out_count <= r_cnt;
    end
  end

  assign out_count = r_out_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_float_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_accumulate
// Purpose  : Directed self-checking bench for float_accumulate (ADD_LATENCY=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_accumulate;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  wire         in_ready;
  wire  [31:0] out_data;
  wire         out_valid;
`ifdef FLOAT_ACC_COUNT_EN
  wire  [31:0] out_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] vd [16];
  bit          vv [16];
  int          vn;

  always #5 clk = ~clk;

  float_accumulate #(.ADD_LATENCY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid)
`ifdef FLOAT_ACC_COUNT_EN
    ,.out_count (out_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives vd/vv one per cycle; in_last rides on the final entry.
  // Returns 1ns into cycle T+1.
  task automatic drive_vec();
    for (int i = 0; i < vn; i++) begin
      in_data  = vd[i];
      in_valid = vv[i];
      in_last  = vv[i] && (i == vn - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Latency of out_valid relative to T, or -1 if it never arrives.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step(); step(); step();
    reset = 1'b0;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", out_data); end
`ifdef FLOAT_ACC_COUNT_EN
    n_tests++;
    if (out_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", out_count); end
`endif
  endtask

  task automatic test_seq8();
    int lat;
    for (int i = 0; i < 8; i++) vv[i] = 1'b1;
    vd[0] = 32'h3F800000; vd[1] = 32'h40000000; vd[2] = 32'h40400000; vd[3] = 32'h40800000;
    vd[4] = 32'h40A00000; vd[5] = 32'h40C00000; vd[6] = 32'h40E00000; vd[7] = 32'h41000000;
    vn = 8;
    drive_vec();
    wait_out(lat);
    n_tests++;
    if (lat != 9) begin n_fail++; $display("FAIL seq8_latency: got %0d expected 9", lat); end
    n_tests++;
    if (out_data !== 32'h42100000) begin n_fail++; $display("FAIL seq8_data: got %h expected 42100000", out_data); end
`ifdef FLOAT_ACC_COUNT_EN
    n_tests++;
    if (out_count !== 32'd8) begin n_fail++; $display("FAIL seq8_count: got %0d expected 8", out_count); end
`endif
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq8_oneshot: got %b expected 0", out_valid); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL seq8_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_single();
    logic [4:0]  rdy;
    logic [4:0]  ov;
    logic [31:0] d4;
    vd[0] = 32'h40200000; vv[0] = 1'b1; vn = 1;
    d4 = '0;
    drive_vec();
    for (int k = 1; k <= 5; k++) begin
      rdy[k-1] = in_ready;
      ov[k-1]  = out_valid;
      if (k == 4) d4 = out_data;
      step();
    end
    n_tests++;
    if (rdy !== 5'b10000) begin n_fail++; $display("FAIL single_ready_T1_T5: got %b expected 10000", rdy); end
    n_tests++;
    if (ov !== 5'b01000) begin n_fail++; $display("FAIL single_valid_T1_T5: got %b expected 01000", ov); end
    n_tests++;
    if (d4 !== 32'h40200000) begin n_fail++; $display("FAIL single_data: got %h expected 40200000", d4); end
  endtask

  task automatic test_bubbles();
    int lat;
    vd[0] = 32'h3F800000; vv[0] = 1'b1;
    vd[1] = 32'h12345678; vv[1] = 1'b0;
    vd[2] = 32'h40000000; vv[2] = 1'b1;
    vd[3] = 32'h87654321; vv[3] = 1'b0;
    vd[4] = 32'h40400000; vv[4] = 1'b1;
    vn = 5;
    drive_vec();
    wait_out(lat);
    n_tests++;
    if (lat != 9) begin n_fail++; $display("FAIL bubbles_latency: got %0d expected 9", lat); end
    n_tests++;
    if (out_data !== 32'h40C00000) begin n_fail++; $display("FAIL bubbles_data: got %h expected 40C00000", out_data); end
`ifdef FLOAT_ACC_COUNT_EN
    n_tests++;
    if (out_count !== 32'd3) begin n_fail++; $display("FAIL bubbles_count: got %0d expected 3", out_count); end
`endif
    step();
  endtask

  task automatic test_pair();
    int lat;
    vd[0] = 32'h3FC00000; vv[0] = 1'b1;
    vd[1] = 32'h3F000000; vv[1] = 1'b1;
    vn = 2;
    drive_vec();
    wait_out(lat);
    n_tests++;
    if (lat != 7) begin n_fail++; $display("FAIL pair_latency: got %0d expected 7", lat); end
    n_tests++;
    if (out_data !== 32'h40000000) begin n_fail++; $display("FAIL pair_data: got %h expected 40000000", out_data); end
    step();
  endtask

  task automatic test_mixed_sign();
    int lat;
    vd[0] = 32'h40A00000; vv[0] = 1'b1;   //  5.0
    vd[1] = 32'hC0400000; vv[1] = 1'b1;   // -3.0
    vd[2] = 32'h3E800000; vv[2] = 1'b1;   //  0.25
    vn = 3;
    drive_vec();
    wait_out(lat);
    n_tests++;
    if (out_data !== 32'h40100000) begin n_fail++; $display("FAIL mixed_data: got %h expected 40100000", out_data); end
    n_tests++;
    if (lat != 9) begin n_fail++; $display("FAIL mixed_latency: got %0d expected 9", lat); end
    step();
  endtask

  task automatic test_reset_mid();
    int nov;
    int lat;
    nov = 0;
    for (int i = 0; i < 5; i++) begin vv[i] = 1'b1; vd[i] = 32'h3F800000 + (i << 23); end
    vn = 5;
    drive_vec();                                   // T+1
    if (out_valid === 1'b1) nov++;
    step();                                        // T+2
    if (out_valid === 1'b1) nov++;
    step();                                        // T+3
    reset = 1'b1;
    if (out_valid === 1'b1) nov++;
    step();                                        // T+4
    reset = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 20; k++) begin
      if (out_valid === 1'b1) nov++;
      step();
    end
    n_tests++;
    if (nov != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", nov); end
    n_tests++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL rstmid_data_cleared: got %h expected 00000000", out_data); end
    vd[0] = 32'h40800000; vv[0] = 1'b1; vn = 1;
    drive_vec();
    wait_out(lat);
    n_tests++;
    if (out_data !== 32'h40800000) begin n_fail++; $display("FAIL rstmid_next_data: got %h expected 40800000", out_data); end
    n_tests++;
    if (lat != 4) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 4", lat); end
`ifdef FLOAT_ACC_COUNT_EN
    n_tests++;
    if (out_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d expected 1", out_count); end
`endif
    step();
  endtask

  task automatic test_drain_hold();
    int lat;
    int pulses;
    vd[0] = 32'h3F800000; vd[1] = 32'h40000000; vd[2] = 32'h40400000;
    vv[0] = 1'b1; vv[1] = 1'b1; vv[2] = 1'b1;
    vn = 3;
    drive_vec();
    // 100.0 held valid throughout the drain.
    in_valid = 1'b1;
    in_data  = 32'h42C80000;
    wait_out(lat);
    in_valid = 1'b0;
    in_data  = '0;
    pulses = (out_valid === 1'b1) ? 1 : 0;
    n_tests++;
    if (out_data !== 32'h40C00000) begin n_fail++; $display("FAIL drain_hold_data: got %h expected 40C00000", out_data); end
    n_tests++;
    if (lat != 9) begin n_fail++; $display("FAIL drain_hold_latency: got %0d expected 9", lat); end
`ifdef FLOAT_ACC_COUNT_EN
    n_tests++;
    if (out_count !== 32'd3) begin n_fail++; $display("FAIL drain_hold_count: got %0d expected 3", out_count); end
`endif
    for (int k = 0; k < 15; k++) begin
      step();
      if (out_valid === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1) begin n_fail++; $display("FAIL drain_hold_pulses: got %0d expected 1", pulses); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    test_reset();
    test_seq8();
    test_single();
    test_bubbles();
    test_pair();
    test_mixed_sign();
    test_reset_mid();
    test_drain_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
